// File: rtl/alu_exec_unit_pkg.sv
// Shared op-code encoding, funct3 constants and compute helpers for the integer execute stage.
// The op field is {funct7[5], funct3, type}; JAL uses a reserved all-ones encoding.
package alu_exec_unit_pkg;

  localparam int ROB_BITS_DEF = 4;

  typedef enum logic [1:0] {
    ALU_T_U = 2'd0,
    ALU_T_I = 2'd1,
    ALU_T_B = 2'd2,
    ALU_T_R = 2'd3
  } alu_type_e;

  localparam logic [5:0] ALU_OP_JAL = 6'h3F;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic      f7;
    logic [2:0] funct3;
    alu_type_e typ;
  } alu_op_t;

  // sub/sra are split so I-type can honour funct7 for shifts only (imm[10] aliases it).
  function automatic logic [31:0] alu_arith(input logic [2:0] f3, input logic sub,
                                            input logic sra, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (f3)
      F3_ADD:  r = sub ? (a - b) : (a + b);
      F3_SLL:  r = a << b[4:0];
      F3_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
      F3_SLTU: r = {31'b0, (a < b)};
      F3_XOR:  r = a ^ b;
      F3_SR:   r = sra ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      F3_OR:   r = a | b;
      F3_AND:  r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:  t = (a == b);
      F3_BNE:  t = (a != b);
      F3_BLT:  t = ($signed(a) < $signed(b));
      F3_BGE:  t = ($signed(a) >= $signed(b));
      F3_BLTU: t = (a < b);
      F3_BGEU: t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/alu_exec_unit_alu_core.sv
// Purely combinational RV32I ALU / branch comparator.
// Produces the result value and whether it is a branch outcome.
module alu_core
  import alu_exec_unit_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] vj,
  input  logic [31:0] vk,
  input  logic [31:0] imm,
  output logic [31:0] value,
  output logic        is_branch
);

  alu_op_t dec;
  assign dec = alu_op_t'(op);

  always_comb begin
    value     = '0;
    is_branch = 1'b0;
    if (op == ALU_OP_JAL) begin
      value = imm;
    end else begin
      case (dec.typ)
        ALU_T_U: value = imm;
        ALU_T_I: value = alu_arith(dec.funct3, 1'b0, dec.f7, vj, imm);
        ALU_T_R: value = alu_arith(dec.funct3, dec.f7, dec.f7, vj, vk);
        ALU_T_B: begin
          is_branch = 1'b1;
          value     = {31'b0, branch_taken(dec.funct3, vj, vk)};
        end
        default: value = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Integer execute stage: accepts one RS entry, registers its ALU result in a single-entry
// buffer and hands it to the RoB broadcast slot, pulsing finish_rdy back to the RS on hand-off.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int ROB_BITS = ROB_BITS_DEF
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                RoB_clear,
  input  logic                issue_valid,
  input  logic [31:0]         vj,
  input  logic [31:0]         vk,
  input  logic [31:0]         imm,
  input  logic [5:0]          op,
  input  logic [ROB_BITS-1:0] dest_id,
  input  logic                out_ack,
  output logic                issue_ready,
  output logic                finish_rdy,
  output logic                out_valid,
  output logic [ROB_BITS-1:0] out_id,
  output logic [31:0]         out_value,
  output logic                out_is_branch
);

  logic [31:0] core_value;
  logic        core_branch;
  logic        accept;

  alu_core u_alu_core (
    .op        (op),
    .vj        (vj),
    .vk        (vk),
    .imm       (imm),
    .value     (core_value),
    .is_branch (core_branch)
  );

  assign issue_ready = rdy_in && (!out_valid || out_ack);
  assign accept      = issue_valid && issue_ready && !RoB_clear;
  // A flushed result is never handed off, even if the RoB acks in the flush cycle.
  assign finish_rdy  = rst_in && rdy_in && out_valid && out_ack && !RoB_clear;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      out_valid     <= 1'b0;
      out_id        <= '0;
      out_value     <= '0;
      out_is_branch <= 1'b0;
    end else if (rdy_in) begin
      if (RoB_clear) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid     <= 1'b1;
        out_id        <= dest_id;
        out_value     <= core_value;
        out_is_branch <= core_branch;
      end else if (out_ack) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
